// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath: drives mux selects, register
// enables and ALU operation each cycle for lw, sw, R-type, I-type ALU, beq and jal.
module multicycle_controller #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_illegal_set;
    logic       w_mem_ready;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;

    // ALU operation for EXECR/EXECI; only R-type may subtract.
    function automatic logic [2:0] alu_decode(input logic [6:0] f_op,
                                              input logic [2:0] f_funct3,
                                              input logic       f_funct7_5);
        logic [2:0] v_ctl;
        case (f_funct3)
            3'b000:  v_ctl = ((f_op == OP_R) && f_funct7_5) ? 3'b001 : 3'b000;
            3'b010:  v_ctl = 3'b101;
            3'b110:  v_ctl = 3'b011;
            3'b111:  v_ctl = 3'b010;
            default: v_ctl = 3'b000;
        endcase
        return v_ctl;
    endfunction

    assign w_mem_ready = USE_MEM_READY ? mem_ready : 1'b1;
    assign state       = r_state;

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            r_state    <= w_next;
            illegal_op <= illegal_op | w_illegal_set;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next        = S_FETCH;
        w_illegal_set = 1'b0;
        case (r_state)
            S_FETCH:    w_next = w_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_next        = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Output decode; strobes are additionally forced low while in reset.
    always_comb begin
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        case (r_state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_ir_write = w_mem_ready;
                w_pc_write = w_mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = alu_decode(op, funct3, funct7_5);
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_decode(op, funct3, funct7_5);
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                w_pc_write  = zero;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
                adr_src = 1'b0;
            end
        endcase
    end

    // Immediate format follows the opcode directly.
    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign pc_write  = w_pc_write  & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign reg_write = w_reg_write & rst_n;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: walks each instruction class
// cycle by cycle and checks state, selects and strobes against hand-computed values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;

    multicycle_controller #(.USE_MEM_READY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .reg_write(reg_write), .alu_control(alu_control), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input string tag, input logic [3:0] exp_pmir);
        chk({tag, "_pc_write"},  {7'd0, pc_write},  {7'd0, exp_pmir[3]});
        chk({tag, "_mem_write"}, {7'd0, mem_write}, {7'd0, exp_pmir[2]});
        chk({tag, "_ir_write"},  {7'd0, ir_write},  {7'd0, exp_pmir[1]});
        chk({tag, "_reg_write"}, {7'd0, reg_write}, {7'd0, exp_pmir[0]});
    endtask

    initial begin
        rst_n = 1'b0; op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b1;
        step(); step(); #1;
        chk("rst_state", {4'd0, state}, 8'd0);
        chk("rst_illegal", {7'd0, illegal_op}, 8'd0);
        strobes("rst", 4'b0000);

        // Release into FETCH of a lw, then reset it from MEMREAD.
        rst_n = 1'b1; #1;
        chk("f0_state", {4'd0, state}, 8'd0);
        strobes("f0", 4'b1010);
        chk("f0_srcb", {6'd0, alu_src_b}, 8'h2);
        chk("f0_res", {6'd0, result_src}, 8'h2);
        step();
        chk("lw_dec", {4'd0, state}, 8'd1);
        chk("lw_dec_a", {6'd0, alu_src_a}, 8'h1);
        chk("lw_dec_b", {6'd0, alu_src_b}, 8'h1);
        step();
        chk("lw_madr", {4'd0, state}, 8'd2);
        chk("lw_madr_a", {6'd0, alu_src_a}, 8'h2);
        step();
        chk("lw_mrd", {4'd0, state}, 8'd3);
        mem_ready = 1'b0; rst_n = 1'b0; #1;
        chk("abort_state", {4'd0, state}, 8'd0);
        strobes("abort", 4'b0000);
        step();
        rst_n = 1'b1; mem_ready = 1'b1; op = 7'b0110011; funct3 = 3'b000; #1;
        chk("rel_state", {4'd0, state}, 8'd0);
        strobes("rel", 4'b1010);

        // add then sub.
        step(); chk("add_dec", {4'd0, state}, 8'd1); strobes("add_dec", 4'b0000);
        step(); chk("add_ex", {4'd0, state}, 8'd6); chk("add_alu", {5'd0, alu_control}, 8'h0);
        chk("add_ex_a", {6'd0, alu_src_a}, 8'h2); chk("add_ex_b", {6'd0, alu_src_b}, 8'h0);
        strobes("add_ex", 4'b0000);
        step(); chk("add_wb", {4'd0, state}, 8'd8); strobes("add_wb", 4'b0001);
        chk("add_wb_res", {6'd0, result_src}, 8'h0);
        step(); funct7_5 = 1'b1; #1;
        chk("add_next", {4'd0, state}, 8'd0); strobes("add_next", 4'b1010);
        step(); step(); chk("sub_ex", {4'd0, state}, 8'd6); chk("sub_alu", {5'd0, alu_control}, 8'h1);
        step(); step(); op = 7'b0010011; #1;

        // addi with instr[30] set must still add; then R-type and.
        step(); step(); chk("addi_ex", {4'd0, state}, 8'd7); chk("addi_alu", {5'd0, alu_control}, 8'h0);
        chk("addi_b", {6'd0, alu_src_b}, 8'h1);
        step(); chk("addi_wb", {4'd0, state}, 8'd8);
        step(); op = 7'b0110011; funct3 = 3'b111; funct7_5 = 1'b0; #1;
        step(); step(); chk("and_alu", {5'd0, alu_control}, 8'h2);
        step(); step(); op = 7'b0010011; funct3 = 3'b010; #1;
        step(); step(); chk("slti_alu", {5'd0, alu_control}, 8'h5);
        step(); step(); funct3 = 3'b110; #1;
        step(); step(); chk("ori_alu", {5'd0, alu_control}, 8'h3);
        step(); step(); op = 7'b0000011; funct3 = 3'b010; #1;

        // lw with two stall cycles in MEMREAD.
        chk("lw2_fetch", {4'd0, state}, 8'd0);
        step(); chk("lw2_imm", {6'd0, imm_src}, 8'h0);
        step(); chk("lw2_madr", {4'd0, state}, 8'd2);
        step(); mem_ready = 1'b0; #1;
        chk("lw2_w1", {4'd0, state}, 8'd3); chk("lw2_w1_adr", {7'd0, adr_src}, 8'h1);
        strobes("lw2_w1", 4'b0000);
        step(); chk("lw2_w2", {4'd0, state}, 8'd3); chk("lw2_w2_adr", {7'd0, adr_src}, 8'h1);
        step(); mem_ready = 1'b1; #1;
        chk("lw2_w3", {4'd0, state}, 8'd3); chk("lw2_w3_adr", {7'd0, adr_src}, 8'h1);
        strobes("lw2_w3", 4'b0000);
        step(); chk("lw2_wb", {4'd0, state}, 8'd4); strobes("lw2_wb", 4'b0001);
        chk("lw2_wb_res", {6'd0, result_src}, 8'h1);
        step(); op = 7'b0100011; #1;
        chk("lw2_next", {4'd0, state}, 8'd0);

        // sw with one stall cycle in MEMWRITE.
        step(); chk("sw_dec", {4'd0, state}, 8'd1); chk("sw_imm", {6'd0, imm_src}, 8'h1);
        step(); chk("sw_madr", {4'd0, state}, 8'd2);
        step(); mem_ready = 1'b0; #1;
        chk("sw_w1", {4'd0, state}, 8'd5); strobes("sw_w1", 4'b0100);
        chk("sw_w1_adr", {7'd0, adr_src}, 8'h1);
        step(); mem_ready = 1'b1; #1;
        chk("sw_w2", {4'd0, state}, 8'd5); strobes("sw_w2", 4'b0100);
        chk("sw_w2_imm", {6'd0, imm_src}, 8'h1);
        step(); op = 7'b1100011; zero = 1'b1; #1;
        chk("sw_next", {4'd0, state}, 8'd0);

        // beq taken then not taken.
        step(); chk("beq1_dec", {4'd0, state}, 8'd1); chk("beq1_imm", {6'd0, imm_src}, 8'h2);
        step(); chk("beq1_st", {4'd0, state}, 8'd9); strobes("beq1", 4'b1000);
        chk("beq1_alu", {5'd0, alu_control}, 8'h1);
        step(); zero = 1'b0; #1;
        chk("beq1_next", {4'd0, state}, 8'd0);
        step(); chk("beq2_imm", {6'd0, imm_src}, 8'h2);
        step(); chk("beq2_st", {4'd0, state}, 8'd9); strobes("beq2", 4'b0000);
        step(); mem_ready = 1'b0; op = 7'b1101111; #1;

        // Fetch stall, then jal.
        chk("fstall", {4'd0, state}, 8'd0); strobes("fstall", 4'b0000);
        step(); mem_ready = 1'b1; #1;
        chk("fstall2", {4'd0, state}, 8'd0); strobes("fstall2", 4'b1010);
        step(); chk("jal_dec", {4'd0, state}, 8'd1); chk("jal_imm", {6'd0, imm_src}, 8'h3);
        step(); chk("jal_st", {4'd0, state}, 8'd10); strobes("jal", 4'b1000);
        chk("jal_a", {6'd0, alu_src_a}, 8'h1); chk("jal_b", {6'd0, alu_src_b}, 8'h2);
        step(); chk("jal_wb", {4'd0, state}, 8'd8); strobes("jal_wb", 4'b0001);
        step(); op = 7'b0000000; #1;
        chk("jal_next", {4'd0, state}, 8'd0);

        // Illegal opcode: back to FETCH with a sticky flag.
        step(); chk("ill_dec", {4'd0, state}, 8'd1); chk("ill_flag0", {7'd0, illegal_op}, 8'h0);
        step(); op = 7'b0110011; funct3 = 3'b000; #1;
        chk("ill_fetch", {4'd0, state}, 8'd0); chk("ill_flag1", {7'd0, illegal_op}, 8'h1);
        step(); step(); chk("ill_sticky", {7'd0, illegal_op}, 8'h1);
        chk("ill_r_ex", {4'd0, state}, 8'd6);
        rst_n = 1'b0; #1;
        chk("ill_clear", {7'd0, illegal_op}, 8'h0);
        chk("ill_rst_state", {4'd0, state}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
